add_seq: RTL and testbench

Multi-precision add/subtract sequencer that sits directly upstream of the combinational 32-bit adder and registers its result. It accepts 32-bit operand beats over a valid/ready handshake and drives the adder's A, B and carry-in ports. It holds the inter-beat carry so that operands of 32×N bits are added least-significant beat first, and it presents each result beat, with flags, on a registered valid/ready output.

---
 rtl/add_seq.sv | 124 ++++++++++++
 tb/tb_add_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_seq.sv
// add_seq: multi-precision add/subtract sequencer in front of a 32-bit
// combinational adder. Operand beats arrive least-significant first; the
// carry between beats is held here, and each result beat is registered
// together with carry-out, last, signed-overflow and beat-index flags.
//
// state   | meaning
// --------+--------------------------------------------------
// S_IDLE  | expecting the first beat of a chain
// S_CHAIN | mid-chain; r_carry and r_beat hold the next beat's context
module add_seq #(
  parameter int MAX_BEATS = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [31:0]      In_A,
  input  logic [31:0]      In_B,
  input  logic             In_Cin,
  input  logic             In_First,
  input  logic             In_Last,
  input  logic             In_Sub,
  output logic [31:0]      Add_A,
  output logic [31:0]      Add_B,
  output logic             Add_Cin,
  input  logic [32:0]      Add_Sum,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [31:0]      Out_Sum,
  output logic             Out_Cout,
  output logic             Out_Last,
  output logic             Out_Ovf,
  output logic [CNT_W-1:0] Out_Beat,
  output logic             Err_Seq,
  output logic             Err_Len
);

  typedef enum logic {S_IDLE, S_CHAIN} state_t;

  state_t             r_state;
  logic               r_carry;
  logic [CNT_W-1:0]   r_beat;
  logic               r_out_valid;
  logic [31:0]        r_out_sum;
  logic               r_out_cout;
  logic               r_out_last;
  logic               r_out_ovf;
  logic [CNT_W-1:0]   r_out_beat;
  logic               r_err_seq;
  logic               r_err_len;

  logic               w_first;
  logic [31:0]        w_bx;
  logic               w_accept;
  logic [CNT_W-1:0]   w_beat;
  logic               w_at_max;
  logic               w_last;
  logic               w_ovf;
  logic               w_seq_err;
  logic               w_len_err;

  // A stray beat in IDLE is treated as a chain start, so first-beat covers it.
  assign w_first   = (r_state == S_IDLE) | In_First;
  assign w_bx      = In_Sub ? ~In_B : In_B;
  assign Add_A     = In_A;
  assign Add_B     = w_bx;
  // Subtract is A + ~B + 1, so the first beat injects the +1.
  assign Add_Cin   = w_first ? (In_Sub ? 1'b1 : In_Cin) : r_carry;

  // No skid buffer: ready is a straight function of the output register.
  assign In_Ready  = !r_out_valid | Out_Ready;
  assign w_accept  = In_Valid & In_Ready;

  assign w_beat    = w_first ? '0 : r_beat;
  assign w_at_max  = (w_beat == CNT_W'(MAX_BEATS - 1));
  assign w_last    = In_Last | w_at_max;
  assign w_ovf     = w_last & (In_A[31] == w_bx[31]) & (Add_Sum[31] != In_A[31]);

  assign w_seq_err = ((r_state == S_IDLE) & !In_First) |
                     ((r_state == S_CHAIN) & In_First);
  assign w_len_err = w_at_max & !In_Last;

  // Chain FSM plus registered result beat; everything advances only on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_carry     <= 1'b0;
      r_beat      <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_beat  <= '0;
      r_err_seq   <= 1'b0;
      r_err_len   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= Add_Sum[31:0];
      r_out_cout  <= Add_Sum[32];
      r_carry     <= Add_Sum[32];
      r_out_beat  <= w_beat;
      r_beat      <= w_beat + CNT_W'(1);
      r_out_last  <= w_last;
      r_out_ovf   <= w_ovf;
      r_state     <= w_last ? S_IDLE : S_CHAIN;
      if (w_seq_err) r_err_seq <= 1'b1;
      if (w_len_err) r_err_len <= 1'b1;
    end else if (Out_Ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign Out_Valid = r_out_valid;
  assign Out_Sum   = r_out_sum;
  assign Out_Cout  = r_out_cout;
  assign Out_Last  = r_out_last;
  assign Out_Ovf   = r_out_ovf;
  assign Out_Beat  = r_out_beat;
  assign Err_Seq   = r_err_seq;
  assign Err_Len   = r_err_len;

endmodule

// File: tb/tb_add_seq.sv
// Bench for add_seq: directed scenarios followed by random multi-beat
// chains checked against whole-number arithmetic on the assembled operands.
module tb_add_seq;

  localparam int MAX_BEATS = 8;
  localparam int CNT_W     = 4;

  logic             clk;
  logic             rst_n;
  logic             In_Valid;
  logic             In_Ready;
  logic [31:0]      In_A;
  logic [31:0]      In_B;
  logic             In_Cin;
  logic             In_First;
  logic             In_Last;
  logic             In_Sub;
  logic [31:0]      Add_A;
  logic [31:0]      Add_B;
  logic             Add_Cin;
  logic [32:0]      Add_Sum;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [31:0]      Out_Sum;
  logic             Out_Cout;
  logic             Out_Last;
  logic             Out_Ovf;
  logic [CNT_W-1:0] Out_Beat;
  logic             Err_Seq;
  logic             Err_Len;

  int n_pass;
  int n_total;

  logic        pre_cin;
  logic [31:0] pre_b;
  logic [31:0] held_sum;

  logic [31:0]  a_arr [MAX_BEATS];
  logic [31:0]  b_arr [MAX_BEATS];
  logic [287:0] big_a, big_b, full, mk, t;
  int           len, nbits;
  logic         sub, cin, sa, sb, sr, exp_ovf, exp_cout;

  add_seq #(.MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In_A(In_A), .In_B(In_B), .In_Cin(In_Cin),
    .In_First(In_First), .In_Last(In_Last), .In_Sub(In_Sub),
    .Add_A(Add_A), .Add_B(Add_B), .Add_Cin(Add_Cin), .Add_Sum(Add_Sum),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Sum(Out_Sum), .Out_Cout(Out_Cout), .Out_Last(Out_Last),
    .Out_Ovf(Out_Ovf), .Out_Beat(Out_Beat),
    .Err_Seq(Err_Seq), .Err_Len(Err_Len)
  );

  // The 32-bit adder that sits downstream of the sequencer.
  assign Add_Sum = {1'b0, Add_A} + {1'b0, Add_B} + {32'd0, Add_Cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one beat, capture the adder drive, wait for accept, step past the edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c,
                      input logic f, input logic l, input logic s);
    int budget;
    In_A = a; In_B = b; In_Cin = c; In_First = f; In_Last = l; In_Sub = s;
    In_Valid = 1'b1;
    #1;
    pre_cin = Add_Cin;
    pre_b   = Add_B;
    budget  = 0;
    while (!In_Ready && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("in_ready_wait", {63'd0, In_Ready}, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    In_Valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    In_Valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1;
    In_A = '0; In_B = '0; In_Cin = 1'b0; In_First = 1'b0; In_Last = 1'b0; In_Sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {63'd0, Out_Valid}, 64'd0);
    chk("rst_sum", {32'd0, Out_Sum}, 64'd0);
    chk("rst_errs", {62'd0, Err_Seq, Err_Len}, 64'd0);
    rst_n = 1'b1;
    chk("rst_in_ready", {63'd0, In_Ready}, 64'd1);

    // Single-beat add with carry out.
    send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("sb_cin", {63'd0, pre_cin}, 64'd0);
    chk("sb_valid", {63'd0, Out_Valid}, 64'd1);
    chk("sb_sum", {32'd0, Out_Sum}, 64'd0);
    chk("sb_cout", {63'd0, Out_Cout}, 64'd1);
    chk("sb_ovf", {63'd0, Out_Ovf}, 64'd0);
    chk("sb_beat", {60'd0, Out_Beat}, 64'd0);
    chk("sb_last", {63'd0, Out_Last}, 64'd1);
    idle_cycle();
    chk("sb_drain", {63'd0, Out_Valid}, 64'd0);

    // 64-bit add in two beats.
    send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("d64_b0_sum", {32'd0, Out_Sum}, 64'd0);
    chk("d64_b0_cout", {63'd0, Out_Cout}, 64'd1);
    chk("d64_b0_last", {63'd0, Out_Last}, 64'd0);
    send(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("d64_b1_cin", {63'd0, pre_cin}, 64'd1);
    chk("d64_b1_sum", {32'd0, Out_Sum}, 64'd1);
    chk("d64_b1_cout", {63'd0, Out_Cout}, 64'd0);
    chk("d64_b1_beat", {60'd0, Out_Beat}, 64'd1);
    chk("d64_b1_last", {63'd0, Out_Last}, 64'd1);

    // Subtracts.
    send(32'd5, 32'd7, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("sub1_cin", {63'd0, pre_cin}, 64'd1);
    chk("sub1_addb", {32'd0, pre_b}, 64'hFFFF_FFF8);
    chk("sub1_sum", {32'd0, Out_Sum}, 64'hFFFF_FFFE);
    chk("sub1_cout", {63'd0, Out_Cout}, 64'd0);
    chk("sub1_ovf", {63'd0, Out_Ovf}, 64'd0);
    send(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("sub2_sum", {32'd0, Out_Sum}, 64'h7FFF_FFFF);
    chk("sub2_ovf", {63'd0, Out_Ovf}, 64'd1);
    idle_cycle();

    // Backpressure: hold, then replace in the same cycle as the handshake.
    Out_Ready = 1'b0;
    send(32'd100, 32'd23, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("bp_sum0", {32'd0, Out_Sum}, 64'd123);
    held_sum = Out_Sum;
    In_A = 32'd1; In_B = 32'd2; In_Cin = 1'b0; In_First = 1'b1; In_Last = 1'b1; In_Sub = 1'b0;
    In_Valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", {63'd0, In_Ready}, 64'd0);
      chk("bp_valid", {63'd0, Out_Valid}, 64'd1);
      chk("bp_hold", {32'd0, Out_Sum}, {32'd0, held_sum});
      @(posedge clk);
    end
    #1;
    Out_Ready = 1'b1;
    #1;
    chk("bp_release_ready", {63'd0, In_Ready}, 64'd1);
    @(posedge clk); #1;
    chk("bp_replace_valid", {63'd0, Out_Valid}, 64'd1);
    chk("bp_replace_sum", {32'd0, Out_Sum}, 64'd3);
    idle_cycle();
    chk("bp_drain", {63'd0, Out_Valid}, 64'd0);

    // Length overrun: nine beats, In_Last only on the ninth.
    do_reset();
    send(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 8; k++)
      send(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("len_b7_beat", {60'd0, Out_Beat}, 64'd7);
    chk("len_b7_last", {63'd0, Out_Last}, 64'd1);
    chk("len_b7_errlen", {63'd0, Err_Len}, 64'd1);
    chk("len_b7_errseq", {63'd0, Err_Seq}, 64'd0);
    send(32'd5, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("len_b8_cin", {63'd0, pre_cin}, 64'd0);
    chk("len_b8_beat", {60'd0, Out_Beat}, 64'd0);
    chk("len_b8_sum", {32'd0, Out_Sum}, 64'd8);
    chk("len_b8_errseq", {63'd0, Err_Seq}, 64'd1);
    chk("len_b8_errlen", {63'd0, Err_Len}, 64'd1);

    // Reset mid-chain.
    do_reset();
    send(32'd1, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mid_b0_sum", {32'd0, Out_Sum}, 64'd2);
    In_Valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_outs", {Out_Sum, 26'd0, Out_Valid, Out_Cout, Out_Last, Out_Ovf, Err_Seq, Err_Len}, 64'd0);
    chk("mid_rst_beat", {60'd0, Out_Beat}, 64'd0);
    chk("mid_rst_ready", {63'd0, In_Ready}, 64'd1);
    send(32'd10, 32'd20, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("mid_cin", {63'd0, pre_cin}, 64'd1);
    chk("mid_beat", {60'd0, Out_Beat}, 64'd0);
    chk("mid_sum", {32'd0, Out_Sum}, 64'd31);
    chk("mid_errseq", {63'd0, Err_Seq}, 64'd1);

    // Random legal chains against whole-number arithmetic.
    do_reset();
    for (int c = 0; c < 25; c++) begin
      len = $urandom_range(1, MAX_BEATS);
      sub = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      for (int k = 0; k < MAX_BEATS; k++) begin
        a_arr[k] = $urandom;
        b_arr[k] = $urandom;
      end
      if ($urandom_range(0, 2) == 0) begin
        a_arr[len-1] = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
        b_arr[len-1] = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
      end
      big_a = '0; big_b = '0;
      for (int k = 0; k < len; k++) begin
        big_a[32*k +: 32] = a_arr[k];
        big_b[32*k +: 32] = b_arr[k];
      end
      full  = sub ? (big_a - big_b) : (big_a + big_b + 288'(cin));
      nbits = 32 * len;
      sa = big_a[nbits-1]; sb = big_b[nbits-1]; sr = full[nbits-1];
      exp_ovf = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
      for (int k = 0; k < len; k++) begin
        mk = (288'd1 << (32 * (k + 1))) - 288'd1;
        if (sub) exp_cout = ((big_a & mk) >= (big_b & mk));
        else begin
          t = (big_a & mk) + (big_b & mk) + 288'(cin);
          exp_cout = t[32*(k+1)];
        end
        send(a_arr[k], b_arr[k], cin, k == 0, k == len - 1, sub);
        chk("rnd_valid", {63'd0, Out_Valid}, 64'd1);
        chk("rnd_sum", {32'd0, Out_Sum}, {32'd0, full[32*k +: 32]});
        chk("rnd_cout", {63'd0, Out_Cout}, {63'd0, exp_cout});
        chk("rnd_beat", {60'd0, Out_Beat}, 64'(k));
        chk("rnd_last", {63'd0, Out_Last}, {63'd0, k == len - 1});
        chk("rnd_ovf", {63'd0, Out_Ovf}, {63'd0, (k == len - 1) && exp_ovf});
      end
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    chk("rnd_no_errs", {62'd0, Err_Seq, Err_Len}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
